// File: rtl/mem_responder_if.sv
// Bus bundle between the memory responder and its CPU/host side: CPU bus,
// host preload channel, store-log drain channel and status.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_adr;
  logic              cpu_memwrite;
  logic [7:0]        cpu_wdata;
  logic [14:0]       cpu_rdata;
  logic              cpu_rdata_oe;
  logic              cpu_reset;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_adr;
  logic [14:0]       ld_data;
  logic              ld_start;
  logic              log_valid;
  logic              log_ready;
  logic [ADDR_W-1:0] log_adr;
  logic [7:0]        log_data;
  logic              log_overflow;
  logic [1:0]        state;

  modport slave (
    input  cpu_adr, cpu_memwrite, cpu_wdata, ld_valid, ld_adr, ld_data, ld_start, log_ready,
    output cpu_rdata, cpu_rdata_oe, cpu_reset, ld_ready, log_valid, log_adr, log_data,
           log_overflow, state
  );

  modport master (
    output cpu_adr, cpu_memwrite, cpu_wdata, ld_valid, ld_adr, ld_data, ld_start, log_ready,
    input  cpu_rdata, cpu_rdata_oe, cpu_reset, ld_ready, log_valid, log_adr, log_data,
           log_overflow, state
  );
endinterface

// File: rtl/mem_responder.sv
// Synchronous 15-bit word store serving the CPU bus, with host preload while the
// CPU is held in reset, a store log FIFO and halt-on-store to HALT_ADR.
module mem_responder #(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          LOG_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    HALT_ADR  = ADDR_W'(8'hFF)
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W     = $clog2(LOG_DEPTH);
  localparam int unsigned ENTRY_W   = ADDR_W + 8;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   cpu_reset_q;
  logic   rd_en_q;
  logic   memwrite_q;
  logic   log_overflow_q;
  logic [14:0] cpu_rdata_q;
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;

  logic [14:0]        mem_q     [MEM_DEPTH];
  logic [ENTRY_W-1:0] log_mem_q [LOG_DEPTH];

  logic running, store, store_first, preload;
  logic log_empty, log_full, push, pop, push_ok;

  assign running     = (state_q == ST_RUN);
  assign store       = running & bus.cpu_memwrite & ~reset;
  assign store_first = store & ~memwrite_q;
  assign preload     = ~running & bus.ld_valid & ~reset;

  assign log_empty = (wr_ptr_q == rd_ptr_q);
  assign log_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop       = bus.log_ready & ~log_empty;
  assign push      = store_first;
  // A full log still accepts a push when the head leaves in the same cycle
  assign push_ok   = push & (~log_full | pop);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD, ST_HALTED: if (bus.ld_start) state_d = ST_RUN;
      ST_RUN:             if (store_first && bus.cpu_adr == HALT_ADR) state_d = ST_HALTED;
      default:            state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      cpu_reset_q    <= 1'b1;
      rd_en_q        <= 1'b0;
      memwrite_q     <= 1'b0;
      log_overflow_q <= 1'b0;
      cpu_rdata_q    <= 15'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= ~running;
      rd_en_q     <= running;
      memwrite_q  <= bus.cpu_memwrite;
      if (running && !bus.cpu_memwrite) cpu_rdata_q <= mem_q[bus.cpu_adr];
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
      if (push && !push_ok) log_overflow_q <= 1'b1;
    end
  end

  // Storage arrays are never cleared; preload and store are exclusive by state
  always_ff @(posedge clk) begin
    if (preload)    mem_q[bus.ld_adr]  <= bus.ld_data;
    else if (store) mem_q[bus.cpu_adr] <= {7'b0, bus.cpu_wdata};
    if (push_ok)    log_mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.cpu_adr, bus.cpu_wdata};
  end

  logic [ENTRY_W-1:0] log_head;
  assign log_head = log_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_rdata_oe = rd_en_q & ~bus.cpu_memwrite;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.ld_ready     = ~running;
  assign bus.log_valid    = ~log_empty;
  assign bus.log_adr      = log_head[ENTRY_W-1:8];
  assign bus.log_data     = log_head[7:0];
  assign bus.log_overflow = log_overflow_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: preload, reads, stores, store log, halt, reset.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_responder_if #(.ADDR_W(8)) bus ();

  mem_responder #(.ADDR_W(8), .LOG_DEPTH(4), .HALT_ADR(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [14:0] d);
    bus.ld_valid = 1'b1; bus.ld_adr = a; bus.ld_data = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic store_pulse(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_adr = a; bus.cpu_wdata = d; bus.cpu_memwrite = 1'b1;
    tick();
    bus.cpu_memwrite = 1'b0;
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [14:0] exp);
    bus.cpu_adr = a; bus.cpu_memwrite = 1'b0;
    tick();
    tick();
    check_eq(tag, 32'(bus.cpu_rdata), 32'(exp));
  endtask

  task automatic start_cpu();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] a, input logic [7:0] d);
    check_eq(tag, {16'd0, bus.log_valid, 7'd0, bus.log_adr}, {16'd0, 1'b1, 7'd0, a});
    check_eq(tag, 32'(bus.log_data), 32'(d));
    bus.log_ready = 1'b1;
    tick();
    bus.log_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_adr = '0; bus.cpu_memwrite = 1'b0; bus.cpu_wdata = '0;
    bus.ld_valid = 1'b0; bus.ld_adr = '0; bus.ld_data = '0; bus.ld_start = 1'b0;
    bus.log_ready = 1'b0;
    tick(); tick();

    check_eq("rst_state",    32'(bus.state), 32'd0);
    check_eq("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_eq("rst_oe",       32'(bus.cpu_rdata_oe), 32'd0);
    check_eq("rst_rdata",    32'(bus.cpu_rdata), 32'd0);
    check_eq("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check_eq("rst_log_valid", 32'(bus.log_valid), 32'd0);
    check_eq("rst_overflow", 32'(bus.log_overflow), 32'd0);

    reset = 1'b0;
    preload(8'h00, 15'h1234);
    preload(8'h01, 15'h002D);
    preload(8'h20, 15'h7FFF);
    preload(8'h30, 15'h7ABC);

    // Release: FSM enters RUN, cpu_reset drops one clock later
    bus.cpu_adr = 8'h01;
    start_cpu();
    check_eq("run_state", 32'(bus.state), 32'd1);
    check_eq("run_ld_ready", 32'(bus.ld_ready), 32'd0);
    check_eq("run_cpu_reset_lag", 32'(bus.cpu_reset), 32'd1);
    tick();
    check_eq("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check_eq("rd_adr1", 32'(bus.cpu_rdata), 32'h002D);
    check_eq("rd_oe", 32'(bus.cpu_rdata_oe), 32'd1);
    read_chk("rd_adr0", 8'h00, 15'h1234);

    // Three-cycle store: OE drops immediately, logged once, high bits cleared
    bus.cpu_adr = 8'h20; bus.cpu_wdata = 8'h2D; bus.cpu_memwrite = 1'b1;
    #1;
    check_eq("st_oe_gate", 32'(bus.cpu_rdata_oe), 32'd0);
    tick(); tick(); tick();
    bus.cpu_memwrite = 1'b0;
    read_chk("st_readback", 8'h20, 15'h002D);
    pop_chk("st_log", 8'h20, 8'h2D);
    check_eq("st_log_once", 32'(bus.log_valid), 32'd0);

    // Overflow: fifth store dropped, first four drain in order
    for (int i = 0; i < 5; i++) store_pulse(8'h40 + 8'(i), 8'hA0 + 8'(i));
    check_eq("ovf_flag", 32'(bus.log_overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_pop", 8'h40 + 8'(i), 8'hA0 + 8'(i));
    check_eq("ovf_drained", 32'(bus.log_valid), 32'd0);
    check_eq("ovf_sticky", 32'(bus.log_overflow), 32'd1);

    // Reset mid-RUN with log non-empty and a store in flight
    store_pulse(8'h50, 8'h11);
    bus.cpu_adr = 8'h30; bus.cpu_wdata = 8'h99; bus.cpu_memwrite = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.cpu_memwrite = 1'b0;
    check_eq("mid_rst_state", 32'(bus.state), 32'd0);
    check_eq("mid_rst_log", 32'(bus.log_valid), 32'd0);
    check_eq("mid_rst_ovf", 32'(bus.log_overflow), 32'd0);
    check_eq("mid_rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    start_cpu();
    read_chk("mid_rst_rd30", 8'h30, 15'h7ABC);
    read_chk("mid_rst_rd0", 8'h00, 15'h1234);

    // Full log with simultaneous push and pop: no overflow, depth stays 4
    for (int i = 0; i < 4; i++) store_pulse(8'h60 + 8'(i), 8'hB0 + 8'(i));
    bus.cpu_adr = 8'h64; bus.cpu_wdata = 8'hB4; bus.cpu_memwrite = 1'b1; bus.log_ready = 1'b1;
    tick();
    bus.cpu_memwrite = 1'b0; bus.log_ready = 1'b0;
    tick();
    check_eq("full_pp_ovf", 32'(bus.log_overflow), 32'd0);
    for (int i = 1; i < 5; i++) pop_chk("full_pp_pop", 8'h60 + 8'(i), 8'hB0 + 8'(i));
    check_eq("full_pp_drained", 32'(bus.log_valid), 32'd0);

    // Store to HALT_ADR: halts, still commits and logs once
    bus.cpu_adr = 8'hFF; bus.cpu_wdata = 8'h5A; bus.cpu_memwrite = 1'b1;
    tick();
    check_eq("halt_state", 32'(bus.state), 32'd2);
    check_eq("halt_cpu_reset_lag", 32'(bus.cpu_reset), 32'd0);
    tick();
    check_eq("halt_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_eq("halt_oe", 32'(bus.cpu_rdata_oe), 32'd0);
    check_eq("halt_ld_ready", 32'(bus.ld_ready), 32'd1);
    bus.cpu_memwrite = 1'b0;
    tick();
    pop_chk("halt_log", 8'hFF, 8'h5A);
    check_eq("halt_log_once", 32'(bus.log_valid), 32'd0);
    start_cpu();
    check_eq("restart_state", 32'(bus.state), 32'd1);
    read_chk("halt_readback", 8'hFF, 15'h005A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
